// File: rtl/rsu_param_responder.sv
// Update-core emulation: parameter read/write port, reconfiguration and watchdog fallback over current/previous/input sets.
// Every access or reconfig holds ABusy for CBusyLat cycles; strobes and rising edges seen outside IDLE are dropped.
module rsu_param_responder #(
  parameter int unsigned CBusyLat     = 4,
  parameter int unsigned CWdogLen     = 20,
  parameter logic [29:0] CFactoryAddr = 30'h0
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AReadParam,
  input  logic        AWriteParam,
  input  logic [2:0]  AParam,
  input  logic [1:0]  AReadSource,
  input  logic [31:0] ADataIn,
  output logic [31:0] ADataOut,
  output logic        ABusy,
  input  logic        AReconfig,
  input  logic        AResetTimer,
  output logic        AReconfigReq,
  output logic [31:0] AReconfigAddr,
  output logic        AWdogExpired
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECONF} state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic        enable;
    logic [11:0] timeout;
    logic [1:0]  cause;
    logic [1:0]  mode;
  } pset_t;

  localparam logic [3:0] CLastCnt    = 4'(CBusyLat - 1);
  localparam pset_t      CFactorySet = '{addr: CFactoryAddr, enable: 1'b0, timeout: 12'h0,
                                         cause: 2'd0, mode: 2'd0};

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_is_read;
  logic [2:0]          r_param;
  logic [1:0]          r_src;
  logic [31:0]         r_wdat;
  pset_t               r_cur, r_prev1, r_in, r_prev2;
  logic                r_reconf_d, r_kick_d;
  logic [CWdogLen-1:0] r_wdog;
  logic [31:0]         r_dout;
  logic                r_req, r_wexp;

  logic  w_start_rd, w_start_wr, w_start_rc;
  logic  w_first, w_last, w_commit, w_reconf_rise, w_kick, w_wdog_on, w_expire;
  pset_t w_rd_set, w_commit_set, w_fallback_set;

  function automatic logic [31:0] f_read(input pset_t s, input logic [2:0] p);
    case (p)
      3'd0:    f_read = {28'h0, s.cause, s.mode};
      3'd2:    f_read = {20'h0, s.timeout};
      3'd3:    f_read = {31'h0, s.enable};
      3'd4:    f_read = {s.addr, 2'b00};
      default: f_read = 32'h0;
    endcase
  endfunction

  assign w_reconf_rise = AReconfig & ~r_reconf_d;
  assign w_kick        = AResetTimer & ~r_kick_d;
  assign w_last        = (r_state != S_IDLE) && (r_cnt == 4'd0);
  assign w_first       = (r_state == S_BUSY) && (r_cnt == CLastCnt);
  assign w_commit      = (r_state == S_RECONF) && w_last;
  assign w_wdog_on     = r_cur.enable && (r_cur.mode == 2'd1) && (r_cur.timeout != 12'h0);
  // A reconfig commit in the same cycle takes precedence over a watchdog expiry.
  assign w_expire      = w_wdog_on && (r_wdog[CWdogLen-1 -: 12] >= r_cur.timeout) && !w_commit;

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_rd = 1'b0;
    w_start_wr = 1'b0;
    w_start_rc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (AReadParam) begin
          w_start_rd = 1'b1;
          w_next     = S_BUSY;
        end else if (AWriteParam) begin
          w_start_wr = 1'b1;
          w_next     = S_BUSY;
        end else if (w_reconf_rise) begin
          w_start_rc = 1'b1;
          w_next     = S_RECONF;
        end
      end
      S_BUSY, S_RECONF: if (r_cnt == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_commit_set         = r_in;
    w_commit_set.mode    = 2'd1;
    w_commit_set.cause   = 2'd1;
    w_fallback_set       = CFactorySet;
    w_fallback_set.cause = 2'd2;
    case (r_src)
      2'd0:    w_rd_set = r_cur;
      2'd1:    w_rd_set = r_prev1;
      2'd2:    w_rd_set = r_in;
      default: w_rd_set = r_prev2;
    endcase
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_cnt     <= 4'd0;
      r_is_read <= 1'b0;
      r_param   <= 3'd0;
      r_src     <= 2'd0;
      r_wdat    <= 32'h0;
      r_in      <= CFactorySet;
      r_dout    <= 32'h0;
    end else begin
      if (w_start_rd || w_start_wr || w_start_rc)
        r_cnt <= CLastCnt;
      else if (r_state != S_IDLE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_start_rd || w_start_wr) begin
        r_is_read <= w_start_rd;
        r_param   <= AParam;
        r_src     <= AReadSource;
        r_wdat    <= ADataIn;
      end
      // Only the input set is writable; other sources still run the busy sequence.
      if (w_first && !r_is_read && r_src == 2'd2) begin
        case (r_param)
          3'd0: begin
            r_in.mode  <= r_wdat[1:0];
            r_in.cause <= r_wdat[3:2];
          end
          3'd2:    r_in.timeout <= r_wdat[11:0];
          3'd3:    r_in.enable  <= r_wdat[0];
          3'd4:    r_in.addr    <= r_wdat[31:2];
          default: ;
        endcase
      end
      if (r_state == S_BUSY && r_is_read && w_last)
        r_dout <= f_read(w_rd_set, r_param);
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_cur      <= CFactorySet;
      r_prev1    <= CFactorySet;
      r_prev2    <= CFactorySet;
      r_reconf_d <= 1'b0;
      r_kick_d   <= 1'b0;
      r_wdog     <= '0;
      r_req      <= 1'b0;
      r_wexp     <= 1'b0;
    end else begin
      r_reconf_d <= AReconfig;
      r_kick_d   <= AResetTimer;
      r_req      <= w_commit | w_expire;
      r_wexp     <= w_expire;
      if (w_commit) begin
        r_prev2 <= r_prev1;
        r_prev1 <= r_cur;
        r_cur   <= w_commit_set;
      end else if (w_expire) begin
        r_prev2 <= r_prev1;
        r_prev1 <= r_cur;
        r_cur   <= w_fallback_set;
      end
      // Saturating counter: it parks at all-ones rather than wrapping back under the timeout.
      if (w_commit || w_expire || w_kick)
        r_wdog <= '0;
      else if (w_wdog_on && !(&r_wdog))
        r_wdog <= r_wdog + {{(CWdogLen-1){1'b0}}, 1'b1};
    end
  end

  assign ABusy         = (r_state != S_IDLE);
  assign ADataOut      = r_dout;
  assign AReconfigReq  = r_req;
  assign AWdogExpired  = r_wexp;
  assign AReconfigAddr = {r_cur.addr, 2'b00};

endmodule

// File: tb/tb_rsu_param_responder.sv
// Bench for rsu_param_responder: directed vector table, hand-written corner sequences,
// then random accesses checked against a field-level model of the four parameter sets.
module tb_rsu_param_responder;

  localparam int CBusyLat = 4;
  localparam int CWdogLen = 20;
  localparam int OP_RD = 0, OP_WR = 1, OP_RC = 2, OP_WD = 3, OP_BOTH = 4;

  logic        AClkH = 1'b0;
  logic        AResetH = 1'b1;
  logic        AReadParam = 1'b0, AWriteParam = 1'b0, AReconfig = 1'b0, AResetTimer = 1'b0;
  logic [2:0]  AParam = 3'd0;
  logic [1:0]  AReadSource = 2'd0;
  logic [31:0] ADataIn = 32'h0;
  logic [31:0] ADataOut, AReconfigAddr;
  logic        ABusy, AReconfigReq, AWdogExpired;

  always #5 AClkH = ~AClkH;

  rsu_param_responder #(.CBusyLat(CBusyLat), .CWdogLen(CWdogLen), .CFactoryAddr(30'h0)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AReadParam(AReadParam), .AWriteParam(AWriteParam),
    .AParam(AParam), .AReadSource(AReadSource), .ADataIn(ADataIn), .ADataOut(ADataOut),
    .ABusy(ABusy), .AReconfig(AReconfig), .AResetTimer(AResetTimer),
    .AReconfigReq(AReconfigReq), .AReconfigAddr(AReconfigAddr), .AWdogExpired(AWdogExpired)
  );

  typedef struct {
    int          op;
    int          src;
    int          prm;
    logic [31:0] dat;
    logic [31:0] exp;
    bit          lat;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Set index follows AReadSource: 0 current, 1 previous1, 2 input, 3 previous2.
  int unsigned m_mode[4], m_cause[4], m_tmo[4], m_en[4];
  logic [29:0] m_addr[4];

  function automatic vec_t mk(int op, int s, int p, logic [31:0] d, logic [31:0] e, bit lat);
    vec_t v;
    v = '{op, s, p, d, e, lat};
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_cause[i] = 0; m_tmo[i] = 0; m_en[i] = 0; m_addr[i] = 30'h0;
    end
  endfunction

  function automatic void m_copy(int dst, int src);
    m_mode[dst] = m_mode[src]; m_cause[dst] = m_cause[src]; m_tmo[dst] = m_tmo[src];
    m_en[dst] = m_en[src]; m_addr[dst] = m_addr[src];
  endfunction

  function automatic void m_commit();
    m_copy(3, 1); m_copy(1, 0); m_copy(0, 2);
    m_mode[0] = 1; m_cause[0] = 1;
  endfunction

  function automatic void m_fallback();
    m_copy(3, 1); m_copy(1, 0);
    m_mode[0] = 0; m_cause[0] = 2; m_tmo[0] = 0; m_en[0] = 0; m_addr[0] = 30'h0;
  endfunction

  function automatic logic [31:0] m_read(int s, int p);
    logic [31:0] v;
    case (p)
      0:       v = m_cause[s] * 4 + m_mode[s];
      2:       v = m_tmo[s];
      3:       v = m_en[s];
      4:       v = {m_addr[s], 2'b00};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic void m_write(int s, int p, logic [31:0] d);
    if (s != 2) return;
    case (p)
      0: begin m_mode[2] = d % 4; m_cause[2] = (d / 4) % 4; end
      2: m_tmo[2] = d % 4096;
      3: m_en[2] = d % 2;
      4: m_addr[2] = d[31:2];
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input int op, input int s, input int p, input logic [31:0] d,
                        output logic [31:0] rd, output int busy_n, output logic req_fall,
                        output logic req_after, output logic [31:0] addr);
    @(negedge AClkH);
    AParam      = p[2:0];
    AReadSource = s[1:0];
    ADataIn     = d;
    AReadParam  = (op == OP_RD || op == OP_BOTH);
    AWriteParam = (op == OP_WR || op == OP_BOTH);
    AReconfig   = (op == OP_RC);
    @(negedge AClkH);
    AReadParam = 1'b0; AWriteParam = 1'b0; AReconfig = 1'b0;
    busy_n = 0;
    while (ABusy && busy_n < 20) begin
      busy_n++;
      @(negedge AClkH);
    end
    rd       = ADataOut;
    req_fall = AReconfigReq;
    addr     = AReconfigAddr;
    @(negedge AClkH);
    req_after = AReconfigReq;
  endtask

  task automatic wdog_window(input int period, input int exp_n, input bit lat_chk);
    int pulses, first, lat_exp;
    pulses  = 0;
    first   = -1;
    lat_exp = m_tmo[0] << (CWdogLen - 12);
    for (int i = 0; i < 2048; i++) begin
      if (period != 0) AResetTimer = ((i / (period / 2)) % 2) == 1;
      @(negedge AClkH);
      if (AWdogExpired) begin
        pulses++;
        if (first < 0) first = i;
        chk("wdog_req_with_expiry", AReconfigReq, 1);
        chk("wdog_fallback_addr", AReconfigAddr, 32'h0);
      end
    end
    AResetTimer = 1'b0;
    chk($sformatf("wdog_pulses_kick%0d", period), pulses, exp_n);
    if (exp_n > 0) m_fallback();
    if (lat_chk) chk($sformatf("wdog_latency_%0d", first), (first >= lat_exp - 8 && first <= lat_exp + 8), 1);
  endtask

  task automatic run_op(input vec_t v);
    logic [31:0] rd, addr;
    logic        rq_f, rq_a;
    int          bn;
    if (v.op == OP_WD) begin
      wdog_window(v.dat, v.exp, v.lat);
    end else begin
      access(v.op, v.src, v.prm, v.dat, rd, bn, rq_f, rq_a, addr);
      chk($sformatf("busy_len_op%0d", v.op), bn, CBusyLat);
      if (v.op == OP_RD || v.op == OP_BOTH)
        chk($sformatf("read_s%0d_p%0d", v.src, v.prm), rd, v.exp);
      else if (v.op == OP_WR)
        m_write(v.src, v.prm, v.dat);
      else begin
        m_commit();
        chk("reconf_req_pulse", rq_f, 1);
        chk("reconf_req_one_cycle", rq_a, 0);
        chk("reconf_addr", addr, v.exp);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[$];
    int          seen, guard, sel, s, p;
    logic [31:0] d;

    tbl.push_back(mk(OP_RD, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(OP_RD, 0, 4, 0, 32'h0, 0));
    tbl.push_back(mk(OP_WR, 2, 4, 32'h0100_0000, 0, 0));
    tbl.push_back(mk(OP_RC, 0, 0, 0, 32'h0100_0000, 0));
    tbl.push_back(mk(OP_RD, 0, 0, 0, 32'h5, 0));
    tbl.push_back(mk(OP_RD, 1, 4, 0, 32'h0, 0));
    tbl.push_back(mk(OP_RD, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(OP_WR, 0, 4, 32'hDEAD_BEEC, 0, 0));
    tbl.push_back(mk(OP_RD, 0, 4, 0, 32'h0100_0000, 0));
    tbl.push_back(mk(OP_WR, 2, 5, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(mk(OP_RD, 2, 5, 0, 32'h0, 0));
    tbl.push_back(mk(OP_WR, 2, 2, 32'hFFFF_F123, 0, 0));
    tbl.push_back(mk(OP_RD, 2, 2, 0, 32'h123, 0));
    tbl.push_back(mk(OP_WR, 2, 2, 32'h1, 0, 0));
    tbl.push_back(mk(OP_WR, 2, 3, 32'h1, 0, 0));
    tbl.push_back(mk(OP_RD, 2, 3, 0, 32'h1, 0));
    tbl.push_back(mk(OP_RC, 0, 0, 0, 32'h0100_0000, 0));
    tbl.push_back(mk(OP_WD, 0, 0, 0, 1, 1));
    tbl.push_back(mk(OP_RD, 0, 0, 0, 32'h8, 0));
    tbl.push_back(mk(OP_RD, 0, 4, 0, 32'h0, 0));
    tbl.push_back(mk(OP_RD, 1, 2, 0, 32'h1, 0));
    tbl.push_back(mk(OP_RD, 3, 0, 0, 32'h5, 0));
    tbl.push_back(mk(OP_RD, 3, 2, 0, 32'h0, 0));
    tbl.push_back(mk(OP_RC, 0, 0, 0, 32'h0100_0000, 0));
    tbl.push_back(mk(OP_WD, 0, 0, 128, 0, 0));
    tbl.push_back(mk(OP_WD, 0, 0, 0, 1, 0));
    tbl.push_back(mk(OP_RD, 0, 0, 0, 32'h8, 0));

    m_reset();
    repeat (3) @(negedge AClkH);
    chk("reset_busy", ABusy, 0);
    chk("reset_dout", ADataOut, 0);
    chk("reset_req", AReconfigReq, 0);
    chk("reset_addr", AReconfigAddr, 0);
    chk("reset_wdog", AWdogExpired, 0);
    AResetH = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Simultaneous read and write strobes: the read is served, the write is lost.
    run_op(mk(OP_BOTH, 2, 2, 32'h777, m_read(2, 2), 0));
    run_op(mk(OP_RD, 2, 2, 0, m_read(2, 2), 0));

    // Write strobe during a busy read must be dropped.
    @(negedge AClkH); AReadParam = 1'b1; AReadSource = 2'd2; AParam = 3'd2;
    @(negedge AClkH); AReadParam = 1'b0;
    @(negedge AClkH); AWriteParam = 1'b1; ADataIn = 32'h555;
    @(negedge AClkH); AWriteParam = 1'b0;
    guard = 0;
    while (ABusy && guard < 20) begin guard++; @(negedge AClkH); end
    seen = 0;
    repeat (4) begin @(negedge AClkH); if (ABusy) seen++; end
    chk("strobe_in_busy_dropped", seen, 0);
    run_op(mk(OP_RD, 2, 2, 0, m_read(2, 2), 0));

    // Reconfig edge raised during busy is consumed, not deferred.
    @(negedge AClkH); AReadParam = 1'b1; AReadSource = 2'd0; AParam = 3'd0;
    @(negedge AClkH); AReadParam = 1'b0;
    @(negedge AClkH); AReconfig = 1'b1;
    guard = 0;
    while (ABusy && guard < 20) begin guard++; @(negedge AClkH); end
    seen = 0;
    repeat (6) begin @(negedge AClkH); if (ABusy || AReconfigReq) seen++; end
    AReconfig = 1'b0;
    chk("reconf_edge_in_busy_dropped", seen, 0);
    run_op(mk(OP_RD, 0, 0, 0, m_read(0, 0), 0));

    // Reset asserted mid-access.
    @(negedge AClkH); AReadParam = 1'b1; AReadSource = 2'd2; AParam = 3'd4;
    @(negedge AClkH); AReadParam = 1'b0;
    @(negedge AClkH);
    chk("busy_before_reset", ABusy, 1);
    AResetH = 1'b1;
    #1;
    chk("busy_drops_on_reset", ABusy, 0);
    chk("dout_after_reset", ADataOut, 0);
    chk("addr_after_reset", AReconfigAddr, 0);
    m_reset();
    @(negedge AClkH); AResetH = 1'b0;
    run_op(mk(OP_RD, 2, 4, 0, m_read(2, 4), 0));

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      s   = $urandom_range(0, 3);
      p   = $urandom_range(0, 7);
      d   = $urandom;
      if (p == 3) d[0] = 1'b0;
      if (sel < 5)      run_op(mk(OP_RD, s, p, 0, m_read(s, p), 0));
      else if (sel < 9) run_op(mk(OP_WR, s, p, d, 0, 0));
      else              run_op(mk(OP_RC, 0, 0, 0, {m_addr[2], 2'b00}, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
